prbs_checker: RTL and testbench

Self-synchronising, parametrised PRBS checker built around the existing combinational `lfsr` core. Each received data word runs through the LFSR in feed-forward mode; the output is the error pattern between the received bits and the bits the sequence predicts. A lock state machine qualifies the stream, and a saturating counter accumulates bit errors. The block sits at the receive end of link and SerDes test paths, opposite a PRBS generator built from the same `lfsr` core.

---
 rtl/prbs_pkg.sv | 27 ++
 rtl/lfsr.sv | 83 ++++++++
 rtl/prbs_checker.sv | 188 ++++++++++++++++++
 tb/tb_prbs_checker.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// +----------------------------------------------------------------------+
// | prbs_pkg: lock-state type, popcount width helper and PRBS taps.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package prbs_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_lock_t;

  // Polynomials in lfsr encoding: bit j set means tap x^j, x^WIDTH implicit.
  localparam logic [6:0]  PRBS7  = 7'h41;
  localparam logic [8:0]  PRBS9  = 9'h021;
  localparam logic [14:0] PRBS15 = 15'h4001;
  localparam logic [22:0] PRBS23 = 23'h040001;
  localparam logic [30:0] PRBS31 = 31'h10000001;

  function automatic int prbs_popcnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr.sv
// +----------------------------------------------------------------------+
// | lfsr: combinational multi-bit LFSR step (Fibonacci or Galois).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter int                    LFSR_FEED_FORWARD = 0,
  parameter int                    REVERSE           = 0,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  generate
    if (LFSR_CONFIG == "GALOIS") begin : g_galois
      logic [LFSR_WIDTH-1:0] w_st;
      logic [DATA_WIDTH-1:0] w_out;
      logic                  w_fb;
      logic                  w_in;
      int                    w_idx;

      always_comb begin
        w_st  = state_in;
        w_out = '0;
        w_fb  = 1'b0;
        w_in  = 1'b0;
        w_idx = 0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
          w_idx        = (REVERSE != 0) ? i : (DATA_WIDTH - 1 - i);
          w_fb         = w_st[LFSR_WIDTH-1] ^ data_in[w_idx];
          w_out[w_idx] = w_fb;
          w_in         = (LFSR_FEED_FORWARD != 0) ? data_in[w_idx] : w_fb;
          w_st         = {w_st[LFSR_WIDTH-2:0], w_in};
          for (int j = 1; j < LFSR_WIDTH; j++) begin
            if (LFSR_POLY[j]) begin
              w_st[j] = w_st[j] ^ w_in;
            end
          end
        end
        data_out  = w_out;
        state_out = w_st;
      end
    end else begin : g_fibonacci
      logic [LFSR_WIDTH-1:0] w_st;
      logic [DATA_WIDTH-1:0] w_out;
      logic                  w_fb;
      int                    w_idx;

      // Feed-forward shifts in the raw input bit, making the state a pure
      // function of the last LFSR_WIDTH received bits.
      always_comb begin
        w_st  = state_in;
        w_out = '0;
        w_fb  = 1'b0;
        w_idx = 0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
          w_idx = (REVERSE != 0) ? i : (DATA_WIDTH - 1 - i);
          w_fb  = w_st[LFSR_WIDTH-1];
          for (int j = 1; j < LFSR_WIDTH; j++) begin
            if (LFSR_POLY[j]) begin
              w_fb = w_fb ^ w_st[j-1];
            end
          end
          w_out[w_idx] = w_fb ^ data_in[w_idx];
          w_st = {w_st[LFSR_WIDTH-2:0],
                  (LFSR_FEED_FORWARD != 0) ? data_in[w_idx] : w_out[w_idx]};
        end
        data_out  = w_out;
        state_out = w_st;
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/prbs_checker.sv
// +----------------------------------------------------------------------+
// | prbs_checker: self-synchronising PRBS checker with lock FSM.         |
// | Optional saturating error counter: PRBS_CHECKER_ERR_CNT_EN.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module prbs_checker
  import prbs_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 31'h10000001,
  parameter int                    REVERSE    = 0,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LOCK_GOOD  = 4,
  parameter int                    LOCK_BAD   = 4,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  input  logic                  cnt_clear,
  output logic [DATA_WIDTH-1:0] err_out,
  output logic                  err_out_valid,
  output logic                  locked,
  output logic                  lock_lost
`ifdef PRBS_CHECKER_ERR_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  err_count
`endif
);

  localparam logic [7:0] c_good_last = 8'(LOCK_GOOD - 1);
  localparam logic [7:0] c_bad_last  = 8'(LOCK_BAD - 1);

  logic [LFSR_WIDTH-1:0] r_st;
  logic [LFSR_WIDTH-1:0] w_st_next;
  logic [DATA_WIDTH-1:0] w_err_next;
  logic [DATA_WIDTH-1:0] r_err_out;
  logic                  r_err_out_valid;
  logic                  w_word_err;

  prbs_lock_t            r_state;
  prbs_lock_t            w_state_next;
  logic [7:0]            r_good_cnt;
  logic [7:0]            w_good_cnt_next;
  logic [7:0]            r_bad_cnt;
  logic [7:0]            w_bad_cnt_next;
  logic                  r_lock_lost;
  logic                  w_lock_lost_next;

  lfsr #(
    .LFSR_WIDTH       (LFSR_WIDTH),
    .LFSR_POLY        (LFSR_POLY),
    .LFSR_CONFIG      ("FIBONACCI"),
    .LFSR_FEED_FORWARD(1),
    .REVERSE          (REVERSE),
    .DATA_WIDTH       (DATA_WIDTH)
  ) u_lfsr (
    .data_in  (data_in),
    .state_in (r_st),
    .data_out (w_err_next),
    .state_out(w_st_next)
  );

  assign w_word_err = |w_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st            <= '0;
      r_err_out       <= '0;
      r_err_out_valid <= 1'b0;
    end else begin
      r_err_out_valid <= data_in_valid;
      if (data_in_valid) begin
        r_st      <= w_st_next;
        r_err_out <= w_err_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_good_cnt  <= 8'd0;
      r_bad_cnt   <= 8'd0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_good_cnt  <= w_good_cnt_next;
      r_bad_cnt   <= w_bad_cnt_next;
      r_lock_lost <= w_lock_lost_next;
    end
  end

  // Thresholds compare against count-1 so the transition lands on the word
  // that would make the count reach the limit.
  always_comb begin
    w_state_next     = r_state;
    w_good_cnt_next  = r_good_cnt;
    w_bad_cnt_next   = r_bad_cnt;
    w_lock_lost_next = 1'b0;
    if (data_in_valid) begin
      case (r_state)
        HUNT: begin
          if (w_word_err) begin
            w_good_cnt_next = 8'd0;
          end else if (r_good_cnt >= c_good_last) begin
            w_state_next    = LOCKED;
            w_good_cnt_next = 8'd0;
            w_bad_cnt_next  = 8'd0;
          end else begin
            w_good_cnt_next = r_good_cnt + 8'd1;
          end
        end
        LOCKED: begin
          if (!w_word_err) begin
            w_bad_cnt_next = 8'd0;
          end else if (r_bad_cnt >= c_bad_last) begin
            w_state_next     = HUNT;
            w_good_cnt_next  = 8'd0;
            w_bad_cnt_next   = 8'd0;
            w_lock_lost_next = 1'b1;
          end else begin
            w_bad_cnt_next = r_bad_cnt + 8'd1;
          end
        end
        default: begin
          w_state_next = HUNT;
        end
      endcase
    end
  end

  assign err_out       = r_err_out;
  assign err_out_valid = r_err_out_valid;
  assign locked        = (r_state == LOCKED);
  assign lock_lost     = r_lock_lost;

`ifdef PRBS_CHECKER_ERR_CNT_EN
  localparam int c_pop_w = prbs_popcnt_width(DATA_WIDTH);
  localparam int c_sum_w = ((CNT_WIDTH > c_pop_w) ? CNT_WIDTH : c_pop_w) + 1;

  logic [c_pop_w-1:0]   w_pop;
  logic [c_sum_w-1:0]   w_sum;
  logic [CNT_WIDTH-1:0] r_err_count;
  logic [CNT_WIDTH-1:0] w_err_count_next;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_pop = w_pop + c_pop_w'(w_err_next[i]);
    end
  end

  // One extra sum bit exposes overflow so the count can clamp instead of wrap.
  always_comb begin
    w_sum            = c_sum_w'(r_err_count) + c_sum_w'(w_pop);
    w_err_count_next = r_err_count;
    if (cnt_clear) begin
      w_err_count_next = '0;
    end else if (data_in_valid && (r_state == LOCKED)) begin
      if (w_sum > c_sum_w'({CNT_WIDTH{1'b1}})) begin
        w_err_count_next = '1;
      end else begin
        w_err_count_next = w_sum[CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else begin
      r_err_count <= w_err_count_next;
    end
  end

  assign err_count = r_err_count;
`else
  logic [CNT_WIDTH-1:0] w_unused_cnt_clear;
  assign w_unused_cnt_clear = {CNT_WIDTH{cnt_clear}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// +----------------------------------------------------------------------+
// | tb_prbs_checker: PRBS9 stream tests for prbs_checker.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_prbs_checker;
  import prbs_pkg::*;

  localparam int DW   = 8;
  localparam int LW   = 9;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          v;
    logic          clr;
    logic [DW-1:0] e_err;
    logic          e_vld;
    logic          e_lock;
    logic          e_lost;
    int            e_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          cnt_clear;
  logic [DW-1:0] err_out;
  logic          err_out_valid;
  logic          locked;
  logic          lock_lost;
`ifdef PRBS_CHECKER_ERR_CNT_EN
  logic [CW-1:0] err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cur      = 0;

  always #5 clk = ~clk;

  prbs_checker #(
    .LFSR_WIDTH(LW),
    .LFSR_POLY (PRBS9),
    .REVERSE   (0),
    .DATA_WIDTH(DW),
    .LOCK_GOOD (4),
    .LOCK_BAD  (4),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .cnt_clear    (cnt_clear),
    .err_out      (err_out),
    .err_out_valid(err_out_valid),
    .locked       (locked),
    .lock_lost    (lock_lost)
`ifdef PRBS_CHECKER_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  // Reference: generator x^9+x^5+1, checker error = r[k]^r[k-5]^r[k-9].
  logic [LW-1:0] g_st;
  logic [LW-1:0] m_hist;
  int            m_good;
  int            m_bad;
  logic          m_locked;
  int            m_cnt;
  logic [DW-1:0] m_err;
  vec_t          sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, cur, act, exp);
    end
  endtask

  task automatic m_reset();
    m_hist   = '0;
    m_good   = 0;
    m_bad    = 0;
    m_locked = 1'b0;
    m_cnt    = 0;
    m_err    = '0;
  endtask

  task automatic gen_word(output logic [DW-1:0] w);
    logic b;
    w = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      b    = g_st[8] ^ g_st[4];
      g_st = {g_st[LW-2:0], b};
      w[i] = b;
    end
  endtask

  task automatic model_step(input logic [DW-1:0] d, input logic v, input logic clr,
                            output vec_t t);
    logic [DW-1:0] e;
    e        = '0;
    t.d      = d;
    t.v      = v;
    t.clr    = clr;
    t.e_lost = 1'b0;
    if (v) begin
      for (int i = DW - 1; i >= 0; i--) begin
        e[i]   = d[i] ^ m_hist[8] ^ m_hist[4];
        m_hist = {m_hist[LW-2:0], d[i]};
      end
      m_err = e;
      if (clr) begin
        m_cnt = 0;
      end else if (m_locked) begin
        m_cnt = m_cnt + $countones(e);
        if (m_cnt > CMAX) m_cnt = CMAX;
      end
      if (!m_locked) begin
        if (e == '0) begin
          m_good++;
          if (m_good == 4) begin
            m_locked = 1'b1;
            m_good   = 0;
            m_bad    = 0;
          end
        end else begin
          m_good = 0;
        end
      end else begin
        if (e != '0) begin
          m_bad++;
          if (m_bad == 4) begin
            m_locked = 1'b0;
            m_good   = 0;
            m_bad    = 0;
            t.e_lost = 1'b1;
          end
        end else begin
          m_bad = 0;
        end
      end
    end else if (clr) begin
      m_cnt = 0;
    end
    t.e_err  = m_err;
    t.e_vld  = v;
    t.e_lock = m_locked;
    t.e_cnt  = m_cnt;
  endtask

  task automatic apply(input vec_t t);
    vec_t x;
    @(negedge clk);
    data_in       = t.d;
    data_in_valid = t.v;
    cnt_clear     = t.clr;
    sb.push_back(t);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("err_out_valid", 32'(err_out_valid), 32'(x.e_vld));
    if (x.e_vld) chk("err_out", 32'(err_out), 32'(x.e_err));
    chk("locked", 32'(locked), 32'(x.e_lock));
    chk("lock_lost", 32'(lock_lost), 32'(x.e_lost));
`ifdef PRBS_CHECKER_ERR_CNT_EN
    chk("err_count", 32'(err_count), 32'(x.e_cnt));
`endif
    cur++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[$];
    vec_t          t;
    logic [DW-1:0] d;
    int            lock_ref;
    int            lock_gap;
    int            nvalid;
    int            nerr_words;
    int            pulses;
    int            bits;
    int            snap;

    rst_n         = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    cnt_clear     = 1'b0;
    m_reset();
    g_st = 9'h1FF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset err_out", 32'(err_out), 32'd0);
    chk("reset err_out_valid", 32'(err_out_valid), 32'd0);
    chk("reset locked", 32'(locked), 32'd0);
    chk("reset lock_lost", 32'(lock_lost), 32'd0);
`ifdef PRBS_CHECKER_ERR_CNT_EN
    chk("reset err_count", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream from reset.
    tbl.delete();
    lock_ref = -1;
    for (int i = 0; i < 20; i++) begin
      gen_word(d);
      model_step(d, 1'b1, 1'b0, t);
      tbl.push_back(t);
      if (t.e_lock && lock_ref < 0) lock_ref = i;
    end
    for (int i = 0; i < 20; i++) begin
      apply(tbl[i]);
      if (i == 5) chk("locked_by_word6", 32'(locked), 32'd1);
      if (i >= 2) chk("clean_err_zero", 32'(err_out), 32'd0);
    end
`ifdef PRBS_CHECKER_ERR_CNT_EN
    chk("clean_err_count", 32'(err_count), 32'd0);
`endif

    // Single bit flip on word 10 while locked.
    tbl.delete();
    for (int i = 0; i < 16; i++) begin
      gen_word(d);
      if (i == 9) d[0] = ~d[0];
      model_step(d, 1'b1, 1'b0, t);
      tbl.push_back(t);
    end
    bits   = 0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      if (i >= 9 && i <= 11) bits += $countones(err_out);
      pulses += int'(lock_lost);
      chk("flip_locked_hold", 32'(locked), 32'd1);
    end
    chk("flip_err_bits", 32'(bits), 32'd3);
    chk("flip_no_lock_lost", 32'(pulses), 32'd0);
`ifdef PRBS_CHECKER_ERR_CNT_EN
    chk("flip_err_count", 32'(err_count), 32'd3);
`endif

    // All-ones words until four consecutive errored words drop lock.
    tbl.delete();
    nerr_words = 0;
    for (int i = 0; i < 8 && nerr_words < 4; i++) begin
      gen_word(d);
      model_step(8'hFF, 1'b1, 1'b0, t);
      tbl.push_back(t);
      if (t.e_err != '0) nerr_words++;
      else nerr_words = 0;
    end
    pulses = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      pulses += int'(lock_lost);
      if (i == tbl.size() - 1) chk("lost_on_4th_bad", 32'(lock_lost), 32'd1);
    end
    chk("lost_pulse_count", 32'(pulses), 32'd1);
    chk("unlocked_after_loss", 32'(locked), 32'd0);
    snap = m_cnt;
    tbl.delete();
    for (int i = 0; i < 3; i++) begin
      gen_word(d);
      model_step(8'hFF, 1'b1, 1'b0, t);
      tbl.push_back(t);
    end
    for (int i = 0; i < 3; i++) apply(tbl[i]);
    chk("hunt_lost_stays_0", 32'(lock_lost), 32'd0);
`ifdef PRBS_CHECKER_ERR_CNT_EN
    chk("hunt_count_frozen", 32'(err_count), 32'(snap));
`endif

    // Clear on an idle cycle, relock, then saturate with repeated flips.
    model_step(8'h00, 1'b0, 1'b1, t);
    apply(t);
    tbl.delete();
    for (int i = 0; i < 8; i++) begin
      gen_word(d);
      model_step(d, 1'b1, 1'b0, t);
      tbl.push_back(t);
    end
    for (int i = 0; i < 35; i++) begin
      gen_word(d);
      if (i % 5 == 0) d[0] = ~d[0];
      model_step(d, 1'b1, 1'b0, t);
      tbl.push_back(t);
    end
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    chk("sat_still_locked", 32'(locked), 32'd1);
`ifdef PRBS_CHECKER_ERR_CNT_EN
    chk("sat_count_max", 32'(err_count), 32'(CMAX));
`endif
    gen_word(d);
    d[0] = ~d[0];
    model_step(d, 1'b1, 1'b1, t);
    apply(t);
    chk("clear_word_errored", 32'(err_out != '0), 32'd1);
`ifdef PRBS_CHECKER_ERR_CNT_EN
    chk("clear_beats_incr", 32'(err_count), 32'd0);
`endif

    // Asynchronous reset between clock edges while locked.
    chk("pre_reset_locked", 32'(locked), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async err_out", 32'(err_out), 32'd0);
    chk("async err_out_valid", 32'(err_out_valid), 32'd0);
    chk("async locked", 32'(locked), 32'd0);
    chk("async lock_lost", 32'(lock_lost), 32'd0);
`ifdef PRBS_CHECKER_ERR_CNT_EN
    chk("async err_count", 32'(err_count), 32'd0);
`endif
    data_in_valid = 1'b0;
    cnt_clear     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    tbl.delete();
    for (int i = 0; i < 6; i++) begin
      gen_word(d);
      model_step(d, 1'b1, 1'b0, t);
      tbl.push_back(t);
    end
    for (int i = 0; i < 6; i++) apply(tbl[i]);
    chk("relock_within_6", 32'(locked), 32'd1);

    // Same seeded stream as the first run, with random idle gaps.
    @(negedge clk);
    data_in_valid = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    g_st = 9'h1FF;
    tbl.delete();
    nvalid = 0;
    for (int c = 0; c < 80 && nvalid < 20; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        model_step(DW'($urandom), 1'b0, 1'b0, t);
      end else begin
        gen_word(d);
        model_step(d, 1'b1, 1'b0, t);
        nvalid++;
      end
      tbl.push_back(t);
    end
    nvalid   = 0;
    lock_gap = -1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (tbl[i].v) begin
        nvalid++;
        if (locked && lock_gap < 0) lock_gap = nvalid - 1;
      end
    end
    chk("gap_lock_word", 32'(lock_gap), 32'(lock_ref));

    @(negedge clk);
    data_in_valid = 1'b0;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
